// File: rtl/spi_slave_pkg.sv
// Shared constants for the byte-wide SPI slave.
package spi_slave_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 4;

    localparam logic [BIT_CNT_W-1:0] CNT_ONE  = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] CNT_FULL = BIT_CNT_W'(BYTE_W);
    localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(BYTE_W - 1);

    // True while a bit counter still has room for another bit in this byte.
    function automatic logic cnt_open(input logic [BIT_CNT_W-1:0] cnt);
        return cnt < CNT_FULL;
    endfunction

endpackage

// File: rtl/spi_slave.sv
// Byte-wide SPI slave, LSB first, full duplex, clocked directly by SCLK.
// MISO is launched on rising edges, MOSI is captured on falling edges.
module spi_slave
    import spi_slave_pkg::*;
(
    input  logic              SCLK,
    input  logic              reset,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [BYTE_W-1:0] slaveDataToSend,
    output logic [BYTE_W-1:0] slaveDataReceived
);

    logic [BYTE_W-1:0]    tx_shift;
    logic [BIT_CNT_W-1:0] tx_cnt;
    logic                 armed;

    // The last received bit goes straight into slaveDataReceived, so the
    // receive shifter only needs to hold the first BYTE_W-1 bits.
    logic [BYTE_W-2:0]    rx_shift;
    logic [BIT_CNT_W-1:0] rx_cnt;

    // Rising edge: load while idle, otherwise drive the next LSB onto MISO.
    always_ff @(posedge SCLK) begin
        if (reset) begin
            tx_shift <= '0;
            tx_cnt   <= '0;
            armed    <= 1'b0;
            MISO     <= 1'b0;
        end else if (CS) begin
            tx_shift <= slaveDataToSend;
            tx_cnt   <= '0;
            armed    <= 1'b0;
            MISO     <= 1'b0;
        end else if (cnt_open(tx_cnt)) begin
            MISO     <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[BYTE_W-1:1]};
            tx_cnt   <= tx_cnt + CNT_ONE;
            armed    <= 1'b1;
        end else begin
            MISO     <= 1'b0;
        end
    end

    // Falling edge: sample MOSI once armed; publish the byte on its last bit.
    // rx_cnt lives in this domain, so the idle clear is applied on the first
    // falling edge that sees armed low (always right after the idle rising edge).
    always_ff @(negedge SCLK) begin
        if (reset) begin
            rx_shift          <= '0;
            rx_cnt            <= '0;
            slaveDataReceived <= '0;
        end else if (!armed) begin
            rx_cnt <= '0;
        end else if (!CS && cnt_open(rx_cnt)) begin
            rx_shift <= {MOSI, rx_shift[BYTE_W-2:1]};
            rx_cnt   <= rx_cnt + CNT_ONE;
            if (rx_cnt == CNT_LAST) begin
                slaveDataReceived <= {MOSI, rx_shift};
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: acts as SPI master, scoreboards both
// the byte received by the slave and the byte captured from MISO.
module tb_spi_slave;

    logic       SCLK = 1'b0;
    logic       reset;
    logic       CS;
    logic       MOSI;
    logic       MISO;
    logic [7:0] slaveDataToSend;
    logic [7:0] slaveDataReceived;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] mask_q[$];
    logic [7:0] model_rx;

    spi_slave dut (
        .SCLK              (SCLK),
        .reset             (reset),
        .CS                (CS),
        .MOSI              (MOSI),
        .MISO              (MISO),
        .slaveDataToSend   (slaveDataToSend),
        .slaveDataReceived (slaveDataReceived)
    );

    always #5 SCLK = ~SCLK;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One master transaction of n SCLK periods; optionally reset after the bits.
    task automatic run_frame(input string name, input logic [7:0] tx_byte,
                             input logic [7:0] mosi_byte, input int n, input bit do_reset);
        logic [7:0] cap;
        logic [7:0] mask;
        logic [7:0] got_mask;
        cap  = '0;
        mask = (n >= 8) ? 8'hFF : 8'((1 << n) - 1);
        if (do_reset)    model_rx = 8'h00;
        else if (n >= 8) model_rx = mosi_byte;
        exp_rx_q.push_back(model_rx);
        exp_tx_q.push_back(tx_byte & mask);
        mask_q.push_back(mask);

        // Idle rising edge loads tx_byte, then the frame opens.
        slaveDataToSend = tx_byte;
        @(posedge SCLK); #1;
        CS = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge SCLK); #1;
            MOSI = (i < 8) ? mosi_byte[i] : 1'($urandom);
            if (i == 3) slaveDataToSend = ~tx_byte;
            @(negedge SCLK);
            if (i < 8) cap[i] = MISO;
            else       check_eq({name, "_miso_tail"}, {7'b0, MISO}, 8'h00);
        end

        @(posedge SCLK); #1;
        if (do_reset) begin
            reset = 1'b1;
            @(posedge SCLK); #1;
            check_eq({name, "_miso_reset"}, {7'b0, MISO}, 8'h00);
            reset = 1'b0;
        end else if (n >= 8) begin
            check_eq({name, "_miso_done"}, {7'b0, MISO}, 8'h00);
        end
        CS = 1'b1;

        got_mask = mask_q.pop_front();
        check_eq({name, "_rx"}, slaveDataReceived, exp_rx_q.pop_front());
        check_eq({name, "_tx"}, cap & got_mask, exp_tx_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        CS              = 1'b1;
        MOSI            = 1'b0;
        slaveDataToSend = 8'h00;
        model_rx        = 8'h00;
        repeat (2) @(posedge SCLK);
        #1;
        check_eq("reset_miso", {7'b0, MISO}, 8'h00);
        check_eq("reset_rx", slaveDataReceived, 8'h00);
        reset = 1'b0;

        run_frame("frame1",   8'b00001001, 8'b01010011, 8,  1'b0);
        run_frame("frame2",   8'b10011000, 8'b00111100, 8,  1'b0);
        run_frame("overclk",  8'h5A,       8'hA5,       12, 1'b0);
        run_frame("abort",    8'hC3,       8'hFF,       4,  1'b0);
        run_frame("after_ab", 8'h7E,       8'h3C,       8,  1'b0);
        run_frame("midreset", 8'h81,       8'hFF,       3,  1'b1);
        run_frame("after_rs", 8'hE7,       8'h96,       8,  1'b0);
        for (int k = 0; k < 4; k++) begin
            run_frame("rand", 8'($urandom), 8'($urandom), 8, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
